// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the 8-digit 7-segment scan
//                driver: digit count, blanking patterns, hex decode table.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Number of digits on the display and the width of a digit index.
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

  // Active-low patterns that leave every segment / every digit dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  typedef logic [DIGIT_W-1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Segments {g,f,e,d,c,b,a}, active-low, indexed by nibble value.
  // The first element of the concatenation is entry 15 (F).
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // One complete displayable value: 8 nibbles plus 8 decimal points.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
  } frame_t;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : CPU debug-value interface into the 7-segment scan driver.
//                The CPU side (master) presents a value, its decimal points
//                and a capture strobe; the scan driver (slave) consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] data;   // nibble k shown on digit k
  logic [NUM_DIGITS-1:0]   dp;     // decimal point k on digit k
  logic                    load;   // capture strobe, sampled every cycle

  modport master (output data, dp, load);
  modport slave  (input  data, dp, load);

endinterface
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex-digit decoder. Maps a nibble and a
//                decimal-point enable to an active-low {dp,g,f,e,d,c,b,a}
//                segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  wire  [3:0] i_nibble,
  input  wire        i_dp,
  output logic [7:0] o_seg
);

  // Table lookup for the digit shape; dp is active-low like the rest.
  always_comb begin
    o_seg = {~i_dp, HEX_TABLE[i_nibble]};
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an 8-digit common-anode
//                7-segment display. A prescaler defines one slot per digit;
//                each slot starts with one blank cycle (anti-ghosting) and
//                then lights the digit until the next slot. Values from the
//                CPU are double-buffered and only promoted to the display
//                register at the frame wrap, so a frame never tears.
//  Options     : SEG_LEADING_ZERO_BLANK_EN - blank digits above the highest
//                non-zero nibble (digit 0 always shown, dp still honoured).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV_CNT = 50000   // clk cycles per digit slot, >= 2
)
(
  input  wire               clk,
  input  wire               rst,
  seg7_scan_driver_if.slave cpu,
  output logic [7:0]        o_seg,
  output logic [7:0]        o_sel,
  output logic              o_frame
);

  localparam int unsigned         PRESC_W  = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [PRESC_W-1:0]  TICK_VAL = PRESC_W'(DIV_CNT - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0] r_presc;     // position inside the current digit slot
  digit_idx_t         r_index;     // digit currently being scanned
  logic               r_show;      // high the cycle after a tick: light digit
  frame_t             r_shadow;    // most recent CPU value not yet shown
  logic               r_pending;   // r_shadow holds data for the next frame
  frame_t             r_disp;      // value used for the whole current frame

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_tick;              // last cycle of a digit slot
  logic       w_wrap;              // tick that moves the scan back to digit 0
  frame_t     w_bus_frame;         // value currently offered by the CPU
  logic [3:0] w_nibble;            // nibble of the digit being lit
  logic       w_dp_bit;            // dp of the digit being lit
  logic [7:0] w_dec_seg;           // decoded pattern of that digit
  logic [7:0] w_lit_seg;           // pattern after optional zero blanking
  logic [7:0] w_sel_lit;           // one-hot active-low select for r_index

  assign w_tick      = (r_presc == TICK_VAL);
  assign w_wrap      = w_tick && (r_index == LAST_DIGIT);
  assign w_bus_frame = {cpu.data, cpu.dp};

  // r_index has already advanced on the tick, so on the show cycle it
  // addresses the digit that owns this slot.
  assign w_nibble  = r_disp.data[{r_index, 2'b00} +: 4];
  assign w_dp_bit  = r_disp.dp[r_index];
  assign w_sel_lit = SEL_OFF ^ (8'b1 << r_index);

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .i_dp     (w_dp_bit),
    .o_seg    (w_dec_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when it and every digit above it are zero.
  // Digit 0 is never blanked so that a zero value still reads "0".
  // Derived from r_disp only, so the mask changes only at a frame wrap.
  logic [NUM_DIGITS-1:0] w_lz_blank;

  assign w_lz_blank[0] = 1'b0;

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign w_lz_blank[k] = (r_disp.data[4*NUM_DIGITS-1:4*k] == '0);
  end

  // A blanked digit keeps its decimal point if enabled.
  assign w_lit_seg = w_lz_blank[r_index] ? {~w_dp_bit, 7'h7F} : w_dec_seg;
`else
  assign w_lit_seg = w_dec_seg;
`endif

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Prescaler: counts 0..DIV_CNT-1 and restarts on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Double buffer: loads land in the shadow and are promoted at the frame
  // wrap; a load coinciding with the wrap goes straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_disp    <= '0;
    end else if (w_wrap) begin
      if (cpu.load) begin
        r_disp <= w_bus_frame;
      end else if (r_pending) begin
        r_disp <= r_shadow;
      end
      r_pending <= 1'b0;
    end else if (cpu.load) begin
      r_shadow  <= w_bus_frame;
      r_pending <= 1'b1;
    end
  end

  // Scan position and display outputs: blank on a tick, light the new digit
  // on the following cycle and hold it until the next tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index <= LAST_DIGIT;
      r_show  <= 1'b0;
      o_seg   <= SEG_OFF;
      o_sel   <= SEL_OFF;
      o_frame <= 1'b0;
    end else begin
      r_show  <= w_tick;
      o_frame <= w_wrap;
      if (w_tick) begin
        r_index <= r_index + 1'b1;
        o_seg   <= SEG_OFF;
        o_sel   <= SEL_OFF;
      end else if (r_show) begin
        o_sel   <= w_sel_lit;
        o_seg   <= w_lit_seg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (DIV_CNT=4).
//                A cycle-level reference model derived from slot arithmetic
//                checks every output on every cycle; table vectors and
//                hand-written sequences cover the directed scenarios.
//  Options     : SEG_LEADING_ZERO_BLANK_EN - adds the zero-blanking checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg;
  logic [7:0] sel;
  logic       frame;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.DIV_CNT(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .cpu     (bus),
    .o_seg   (seg),
    .o_sel   (sel),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: outputs follow from the edge count since reset.
  // Edge n (n>=1): tick when n%DIV==0; slot k=n/DIV shows digit (k-1)%8.
  // --------------------------------------------------------------------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [7:0] ref_seg(input logic [31:0] v, input logic [7:0] dps, input int d);
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        dpo;
    upper = v >> (4 * d);
    nib   = upper[3:0];
    dpo   = ~dps[d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 32'd0) return {dpo, 7'h7F};
`endif
    return {dpo, seg_tab[nib]};
  endfunction

  int         n_edge;
  logic [31:0] m_disp_d, m_lat_d;
  logic [7:0]  m_disp_p, m_lat_p;
  bit          m_pend;
  logic [7:0]  e_seg, e_sel;
  logic        e_frame;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    int k;
    int d;
    bit tk;
    bit wrap;
    if (rst) begin
      n_edge = 0;
      m_disp_d = '0; m_disp_p = '0; m_lat_d = '0; m_lat_p = '0; m_pend = 1'b0;
      e_seg = 8'hFF; e_sel = 8'hFF; e_frame = 1'b0;
    end else begin
      n_edge++;
      tk   = (n_edge % DIV == 0);
      k    = n_edge / DIV;
      wrap = tk && ((k - 1) % 8 == 0);
      if (wrap) begin
        if (bus.load) begin
          m_disp_d = bus.data; m_disp_p = bus.dp;
        end else if (m_pend) begin
          m_disp_d = m_lat_d; m_disp_p = m_lat_p;
        end
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_lat_d = bus.data; m_lat_p = bus.dp; m_pend = 1'b1;
      end
      if (n_edge < DIV || tk) begin
        e_seg = 8'hFF; e_sel = 8'hFF; e_frame = wrap;
      end else begin
        d = (k - 1) % 8;
        e_sel = ~(8'd1 << d);
        e_seg = ref_seg(m_disp_d, m_disp_p, d);
        e_frame = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check8("model_seg", seg, e_seg);
      check8("model_sel", sel, e_sel);
      check8("model_frame", {7'b0, frame}, {7'b0, e_frame});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all start and end on a falling edge)
  // --------------------------------------------------------------------------
  task automatic load_val(input logic [31:0] d, input logic [7:0] p);
    bus.load = 1'b1; bus.data = d; bus.dp = p;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frame();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (frame) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_frame: no o_frame pulse within 100 cycles, expected one");
    end
  endtask

  task automatic wait_digit(input int d);
    bit         ok = 1'b0;
    logic [7:0] want;
    want = ~(8'd1 << d);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sel == want) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_digit: digit %0d never selected, last sel %02h expected %02h", d, sel, want);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    int          digit;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cnt;

    vecs[0] = '{32'h89AB_CDEF, 8'h01, 0, 8'h0E};
    vecs[1] = '{32'h89AB_CDEF, 8'h01, 7, 8'h80};
    vecs[2] = '{32'h1234_5678, 8'h00, 3, 8'h92};
    vecs[3] = '{32'h1234_5678, 8'h00, 7, 8'hF9};
    vecs[4] = '{32'hDEAD_BEEF, 8'hF0, 4, 8'h21};
    vecs[5] = '{32'hDEAD_BEEF, 8'hF0, 2, 8'h86};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    vecs[6] = '{32'h0000_000C, 8'h80, 7, 8'h7F};
`else
    vecs[6] = '{32'h0000_000C, 8'h80, 7, 8'h40};
`endif
    vecs[7] = '{32'h0000_0009, 8'h00, 0, 8'h90};

    bus.load = 1'b0; bus.data = '0; bus.dp = '0;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check8("reset_sel", sel, 8'hFF);
    check8("reset_seg", seg, 8'hFF);
    check8("reset_frame", {7'b0, frame}, 8'h00);

    // Reset release with a load held high: first digit after edge 5.
    rst = 1'b0; bus.load = 1'b1; bus.data = 32'h0; bus.dp = 8'h00;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check8("first_sel_blank", sel, 8'hFF);
      check8("first_seg_blank", seg, 8'hFF);
    end
    check8("first_frame", {7'b0, frame}, 8'h01);
    bus.load = 1'b0;
    @(negedge clk);
    check8("first_sel_lit", sel, 8'hFE);
    check8("first_seg_lit", seg, 8'hC0);

    // Table vectors: load, let the frame wrap adopt it, inspect one digit.
    for (int v = 0; v < 8; v++) begin
      load_val(vecs[v].data, vecs[v].dp);
      wait_frame();
      wait_digit(vecs[v].digit);
      check8("vec_seg", seg, vecs[v].exp_seg);
    end

    // Frame period.
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (frame) break;
    end
    check8("frame_period", 8'(cnt), 8'd32);

    // No tearing: a load mid-frame only shows from the next frame.
    load_val(32'h1111_1111, 8'h00);
    wait_frame();
    wait_digit(3);
    load_val(32'h2222_2222, 8'h00);
    for (int d = 4; d < 8; d++) begin
      wait_digit(d);
      check8("tear_old", seg, 8'hF9);
    end
    wait_frame();
    wait_digit(0);
    check8("tear_new0", seg, 8'hA4);
    wait_digit(7);
    check8("tear_new7", seg, 8'hA4);

    // Load coinciding with the frame wrap bypasses the shadow and clears
    // the earlier pending value.
    wait_frame();
    load_val(32'h0000_0007, 8'h00);
    wait_digit(7);
    @(negedge clk);
    @(negedge clk);
    bus.load = 1'b1; bus.data = 32'h0000_0005; bus.dp = 8'h00;
    @(negedge clk);
    bus.load = 1'b0;
    check8("coinc_frame", {7'b0, frame}, 8'h01);
    @(negedge clk);
    check8("coinc_sel", sel, 8'hFE);
    check8("coinc_seg", seg, 8'h92);
    wait_frame();
    wait_digit(0);
    check8("coinc_no_pending", seg, 8'h92);

    // Reset mid-frame discards pending data.
    load_val(32'hFFFF_FFFF, 8'h00);
    wait_frame();
    load_val(32'h3333_3333, 8'h00);
    wait_digit(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check8("midrst_sel", sel, 8'hFF);
    check8("midrst_seg", seg, 8'hFF);
    check8("midrst_frame", {7'b0, frame}, 8'h00);
    wait_frame();
    wait_digit(0);
    check8("midrst_d0", seg, 8'hC0);
    wait_digit(5);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check8("midrst_d5", seg, 8'hFF);
`else
    check8("midrst_d5", seg, 8'hC0);
`endif

`ifdef SEG_LEADING_ZERO_BLANK_EN
    load_val(32'h0000_00A3, 8'h03);
    wait_frame();
    wait_digit(0);
    check8("lz_d0", seg, 8'h30);
    wait_digit(1);
    check8("lz_d1", seg, 8'h08);
    wait_digit(2);
    check8("lz_d2", seg, 8'hFF);
    wait_digit(7);
    check8("lz_d7", seg, 8'hFF);
    load_val(32'h0, 8'h00);
    wait_frame();
    wait_digit(0);
    check8("lz_zero", seg, 8'hC0);
`endif

    // Random loads checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.load = ($urandom_range(0, 5) == 0);
      bus.data = $urandom;
      bus.dp   = 8'($urandom);
    end
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
